// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit controllers.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Full bit period in clock cycles from the half-bit count.
    function automatic int bit_period(input int half);
        return 2 * half;
    endfunction

endpackage

// File: rtl/fifo.sv
// Generic show-ahead FIFO: head entry visible combinationally on head_dat.
// Latency: a push is visible on head_dat the cycle after its write edge.
// Backpressure: push is dropped when full unless a pop happens the same cycle.
// Ports: clk/reset (sync, active-high); push/push_dat write side;
//        pop read side; head_dat, empty, full status.
module fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_pop;
    logic          do_push;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign head_dat = mem_q[rd_ptr_q];

    // A pop frees a slot in the same edge, so a push into a full FIFO
    // is still accepted when it coincides with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, sampling FSM and shift register.
// Latency: rx_valid pulses for one cycle at the mid-stop-bit sample.
// Backpressure: none; the consumer must take rx_data while rx_valid is high.
// Ports: clk/reset (sync, active-high); rxd async serial in; rx_valid/rx_data
//        received byte; frame_err one-cycle pulse on a low stop bit; busy mid-frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 5208
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rxd,
    output logic              rx_valid,
    output logic [BYTE_W-1:0] rx_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int BIT_CYC = bit_period(CLK_PER_HALF_BIT);
    localparam int CNT_W   = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BIT_CYC - 1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              rxs;

    assign rxs     = sync2_q;
    assign rx_data = shift_q;
    assign busy    = (state_q != IDLE);

    always_comb begin
        sync1_d   = rxd;
        sync2_d   = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_valid  = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                // Mid start bit: a line already back high was only a glitch.
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d     = '0;
                    shift_d   = {rxs, shift_q[BYTE_W-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start is not missed.
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rxs) rx_valid  = 1'b1;
                    else     frame_err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Synchroniser preset to idle-high so reset never looks like a start.
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

endmodule

// File: rtl/in_controller.sv
// Receive-side I/O controller: UART bytes buffered in a FIFO for core and bootloader.
// Latency: byte visible on dout the cycle after its mid-stop-bit sample.
// Backpressure: core read on empty FIFO raises stall; full FIFO drops bytes (sticky overflow).
// Ports: clk/reset (sync, active-high); rxd serial in; read core request;
//        rd_en_bootloader pop request; dout/dout_valid head byte; stall;
//        overflow and frame_err sticky flags; busy receiver mid-frame.
module in_controller
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int FIFO_DEPTH       = 2**14   // power of 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rxd,
    input  logic              read,
    input  logic              rd_en_bootloader,
    output logic [BYTE_W-1:0] dout,
    output logic              dout_valid,
    output logic              stall,
    output logic              overflow,
    output logic              frame_err
    ,
    output logic              busy
);

    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_ferr;
    logic [BYTE_W-1:0] head_dat;
    logic              empty;
    logic              full;
    logic              pop;
    logic              overflow_q, overflow_d;
    logic              frame_err_q, frame_err_d;

    uart_rx #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .frame_err(rx_ferr),
        .busy     (busy)
    );

    // Both requesters share one pop per cycle.
    assign pop = (read | rd_en_bootloader) & ~empty;

    fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    (BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (rx_valid),
        .push_dat(rx_data),
        .pop     (pop),
        .head_dat(head_dat),
        .empty   (empty),
        .full    (full)
    );

    assign dout       = empty ? '0 : head_dat;
    assign dout_valid = ~empty;
    assign stall      = read & empty;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

    always_comb begin
        overflow_d  = overflow_q | (rx_valid & full & ~pop);
        frame_err_d = frame_err_q | rx_ferr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_in_controller.sv
// Bench for in_controller: directed scenarios plus randomized traffic,
// checked every cycle against a byte-level queue model.
module tb_in_controller;

    localparam int HALF  = 4;
    localparam int BITC  = 2 * HALF;
    localparam int DEPTH = 4;
    // Line edge -> 2 synchroniser edges -> idle detect -> half bit -> 9 full bits.
    localparam int PUSH_LAT = 3 + HALF + 9 * BITC;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic       read;
    logic       rd_en_bootloader;
    logic [7:0] dout;
    logic       dout_valid;
    logic       stall;
    logic       overflow;
    logic       frame_err;
    logic       busy;

    in_controller #(
        .CLK_PER_HALF_BIT(HALF),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rxd             (rxd),
        .read            (read),
        .rd_en_bootloader(rd_en_bootloader),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .stall           (stall),
        .overflow        (overflow),
        .frame_err       (frame_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         edge_n;
        logic [7:0] b;
        bit         ok;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] mq[$];
    bit         m_ovf  = 1'b0;
    bit         m_ferr = 1'b0;
    int         ecount = 0;
    bit         mon_en = 1'b0;

    always @(posedge clk) begin
        ev_t e;
        bit  do_pop;
        bit  do_push;
        ecount++;
        do_push = 1'b0;
        if (reset) begin
            mq.delete();
            evq.delete();
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            do_pop = (read || rd_en_bootloader) && (mq.size() > 0);
            if (evq.size() > 0 && evq[0].edge_n == ecount) begin
                e = evq.pop_front();
                if (e.ok) begin
                    if (mq.size() < DEPTH || do_pop) do_push = 1'b1;
                    else                             m_ovf   = 1'b1;
                end else begin
                    m_ferr = 1'b1;
                end
            end
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e.b);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("dout_valid", 32'(dout_valid), 32'(mq.size() > 0));
            check("stall", 32'(stall), 32'(read && mq.size() == 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("frame_err", 32'(frame_err), 32'(m_ferr));
            if (mq.size() > 0) check("dout", 32'(dout), 32'(mq[0]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        ev_t        e;
        logic [9:0] fr;
        e.edge_n = ecount + PUSH_LAT;
        e.b      = b;
        e.ok     = ok;
        evq.push_back(e);
        fr = {ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            tick(BITC);
        end
        rxd = 1'b1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    bit done = 1'b0;

    initial begin
        reset            = 1'b1;
        rxd              = 1'b1;
        read             = 1'b0;
        rd_en_bootloader = 1'b0;
        tick(3);
        mon_en = 1'b1;
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_dout_valid", 32'(dout_valid), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        tick(2);

        // Single byte, no read
        fork
            send_byte(8'hA5, 1'b1);
            begin
                tick(40);
                check("single_busy", 32'(busy), 32'h1);
                tick(PUSH_LAT - 1 - 40);
                check("single_pre_valid", 32'(dout_valid), 32'h0);
                tick();
                check("single_valid", 32'(dout_valid), 32'h1);
                check("single_dout", 32'(dout), 32'hA5);
            end
        join
        read = 1'b1;
        check("single_read_stall", 32'(stall), 32'h0);
        tick();
        read = 1'b0;
        check("single_after_pop", 32'(dout_valid), 32'h0);

        // Read held on empty FIFO
        read = 1'b1;
        tick(2);
        check("stall_empty", 32'(stall), 32'h1);
        fork
            send_byte(8'h3C, 1'b1);
            begin
                tick(PUSH_LAT - 1);
                check("stall_stop_cycle", 32'(stall), 32'h1);
                tick();
                check("stall_drop", 32'(stall), 32'h0);
                check("stall_dout", 32'(dout), 32'h3C);
            end
        join
        read = 1'b0;
        tick();
        check("stall_one_pop", 32'(dout_valid), 32'h0);

        // Glitch on rxd
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(2 * BITC);
        check("glitch_busy", 32'(busy), 32'h0);
        check("glitch_nopush", 32'(dout_valid), 32'h0);

        // Framing error
        send_byte(8'h55, 1'b0);
        tick(2 * BITC);
        check("ferr_flag", 32'(frame_err), 32'h1);
        check("ferr_empty", 32'(dout_valid), 32'h0);
        pulse_reset();

        // Overflow: five bytes into a four-entry FIFO
        for (int v = 1; v <= 5; v++) send_byte(8'(v), 1'b1);
        tick(2);
        check("ovf_flag", 32'(overflow), 32'h1);
        read = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            check("ovf_order", 32'(dout), 32'(v));
            tick();
        end
        read = 1'b0;
        check("ovf_drained", 32'(dout_valid), 32'h0);
        pulse_reset();

        // Full FIFO with simultaneous bootloader pop
        for (int v = 1; v <= 4; v++) send_byte(8'(v), 1'b1);
        fork
            send_byte(8'h05, 1'b1);
            begin
                tick(PUSH_LAT - 1);
                rd_en_bootloader = 1'b1;
                tick();
                rd_en_bootloader = 1'b0;
            end
        join
        tick(2);
        check("fullpop_no_ovf", 32'(overflow), 32'h0);
        rd_en_bootloader = 1'b1;
        for (int v = 2; v <= 5; v++) begin
            check("fullpop_order", 32'(dout), 32'(v));
            tick();
        end
        rd_en_bootloader = 1'b0;
        check("fullpop_drained", 32'(dout_valid), 32'h0);

        // Reset during data bit 3, held until the stop bit
        fork
            send_byte(8'h77, 1'b1);
            begin
                tick(4 * BITC + 3);
                reset = 1'b1;
                tick(5 * BITC - 1);
                reset = 1'b0;
            end
        join
        tick(2 * BITC);
        check("rstmid_nopush", 32'(dout_valid), 32'h0);
        check("rstmid_no_ferr", 32'(frame_err), 32'h0);
        check("rstmid_idle", 32'(busy), 32'h0);
        send_byte(8'h77, 1'b1);
        check("rstmid_fresh", 32'(dout), 32'h77);
        read = 1'b1;
        tick();
        read = 1'b0;

        // Randomized traffic
        fork
            begin
                for (int it = 0; it < 30; it++) begin
                    int k;
                    k = $urandom_range(0, 9);
                    if (k < 7) begin
                        send_byte(8'($urandom), 1'b1);
                    end else if (k == 7) begin
                        send_byte(8'($urandom), 1'b0);
                        tick(2 * BITC);
                    end else if (k == 8) begin
                        rxd = 1'b0;
                        tick($urandom_range(1, 3));
                        rxd = 1'b1;
                        tick(2 * BITC);
                    end else begin
                        tick($urandom_range(1, 20));
                    end
                end
                tick(2 * BITC);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    read             = ($urandom_range(0, 3) == 0);
                    rd_en_bootloader = ($urandom_range(0, 7) == 0);
                    tick();
                end
                read             = 1'b0;
                rd_en_bootloader = 1'b0;
            end
        join
        rd_en_bootloader = 1'b1;
        tick(DEPTH + 1);
        rd_en_bootloader = 1'b0;
        check("final_drained", 32'(dout_valid), 32'h0);
        tick(2);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/in_controller.md
Name: in_controller

Overview:
Receive-side I/O controller. Deserialises 8N1 UART frames from the host on rxd and buffers the bytes in a FIFO. Serves them to the core's read instruction, with a stall while the FIFO is empty, and to the bootloader. Mirror of the transmit-side output controller and shares its baud parameter.

Parameters:
CLK_PER_HALF_BIT, 5208, clock cycles per half UART bit period; full bit = 2*CLK_PER_HALF_BIT.
FIFO_DEPTH, 2**14, receive FIFO entries; must be a power of 2.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rxd  in  1  UART serial input, asynchronous, idle high
read  in  1  core read request (load-from-input instruction)
rd_en_bootloader  in  1  bootloader pop request
dout  out  8  FIFO head byte; valid when dout_valid=1
dout_valid  out  1  FIFO not empty
stall  out  1  core must hold its PC: read & empty
overflow  out  1  sticky: a received byte was dropped because the FIFO was full
frame_err  out  1  sticky: a stop bit was sampled low
busy  out  1  receiver is mid-frame (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: dout=0, dout_valid=0, stall=0, overflow=0, frame_err=0, busy=0.
- Reset clears FIFO pointers and count, forces the receive FSM to IDLE and sets both synchroniser flops to 1, so no false start is seen after reset.
- Reset asserted mid-frame discards the partial byte.
- rxd passes through a 2-flop synchroniser; all FSM samples use the second flop (rxs).
- Receive FSM, one counter cnt:
  - IDLE: on rxs=0, cnt<=0 and go to START.
  - START: when cnt=CLK_PER_HALF_BIT-1, sample mid start bit. If rxs=1 it was a glitch: back to IDLE. Otherwise go to DATA with bit index 0.
  - DATA: every 2*CLK_PER_HALF_BIT cycles sample rxs into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: sample after 2*CLK_PER_HALF_BIT cycles, at mid stop bit. If rxs=1, push the byte; if rxs=0, set frame_err and discard the byte. Go to IDLE in the same cycle, so a back-to-back start bit half a bit later is caught.
- Push latency: a byte enters the FIFO on the clk edge of the stop-bit sample. dout_valid rises the next cycle if the FIFO was empty.
- FIFO is show-ahead: dout = mem[rd_ptr] combinationally from registered state. dout=0 when empty is not required; verify dout only when dout_valid=1.
- Pop = (read | rd_en_bootloader) & ~empty. At most one pop per cycle, even if both requests are high.
- Core read:
  - read=1 and not empty: dout is valid this cycle, pop on this edge, stall=0.
  - read=1 and empty: stall=1 combinationally, no pop; the core re-presents read every cycle.
  - A push into an empty FIFO is visible the next cycle; stall drops then. There is no same-cycle bypass.
- Full FIFO on push: the byte is dropped and overflow is set, unless a pop happens the same cycle. In that case both occur and the count is unchanged.
- Push and pop on a non-empty, non-full FIFO: both occur.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits. empty = (count==0), full = (count==FIFO_DEPTH).
- overflow and frame_err clear only on reset.

Decomposition:
- Shared package uart_pkg:
  - typedef enum rx_state_t {IDLE, START, DATA, STOP}.
  - Constant BYTE_W=8.
  - Function bit_period(half) = 2*half.
- Sub-module uart_rx: synchroniser, FSM, shift register. Outputs a one-cycle rx_valid plus rx_data, and frame_err.
- The existing fifo module is reused for buffering; it requires a full-with-simultaneous-pop accept path.
- in_controller contains the arbitration, stall and sticky flags.

Test Plan:
Bench uses CLK_PER_HALF_BIT=4 and FIFO_DEPTH=4.
- Single byte: send 0xA5 on rxd with read=0. Required: dout_valid rises 1 cycle after the mid-stop sample; dout=0xA5. Then read=1 for 1 cycle: pop happens, stall=0, dout_valid returns to 0.
- Stall: read=1 held with the FIFO empty, then send 0x3C. Required: stall=1 throughout the frame and for the stop-sample cycle. stall=0 with dout=0x3C the next cycle; exactly one pop.
- Glitch and framing:
  - 3-cycle low pulse on rxd: no push, busy returns to 0.
  - Frame 0x55 with stop bit low: frame_err=1, FIFO still empty.
- Overflow: send 5 back-to-back bytes 0x01..0x05 with no reads. Required: FIFO holds 0x01..0x04, overflow=1. Then pop 4 times: order 0x01, 0x02, 0x03, 0x04.
- Full with simultaneous pop: FIFO full; rd_en_bootloader=1 on the stop-sample cycle of 0x05. Required: 0x01 popped, 0x05 accepted, overflow stays 0. Draining yields 0x02..0x05, exercising pointer wrap.
- Reset mid-frame: assert reset during DATA bit 3 of 0x77, then let the rest of the frame play out. Required: no push, no frame_err. A fresh 0x77 sent afterwards is received correctly.
